lsu_ctrl: RTL

Load/store control unit between the datapath's execute stage and `data_memory`. It accepts one memory request per valid/ready handshake, checks alignment and range, and drives `data_memory` for exactly one access cycle with the correct `load_format`/`store_format` encoding. It then sign- or zero-extends load data and holds a registered response until the consumer accepts it.

---
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and data_memory: validates a request,
// drives one memory access cycle, then holds an extended response until taken.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for a request; decode errors on acceptance
// S_ACCESS | single memory cycle with exactly one enable high
// S_RESP   | response held until resp_ready
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  load_format,
  output logic [1:0]  store_format,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;

  logic [2:0]  w_size_m1;
  logic        w_illegal;
  logic        w_misaligned;
  logic [64:0] w_last_byte;
  logic        w_out_of_range;
  logic [1:0]  w_err_code;
  logic [2:0]  w_load_fmt;
  logic [63:0] w_load_ext;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);

  always_comb begin
    w_size_m1 = 3'd0;
    case (req_funct3[1:0])
      2'b00: w_size_m1 = 3'd0;
      2'b01: w_size_m1 = 3'd1;
      2'b10: w_size_m1 = 3'd3;
      2'b11: w_size_m1 = 3'd7;
      default: w_size_m1 = 3'd0;
    endcase
  end

  // 65-bit sum so an address near 2^64 cannot wrap back into range
  assign w_last_byte    = {1'b0, req_addr} + {62'd0, w_size_m1};
  assign w_out_of_range = (w_last_byte >= 65'(MEM_BYTES));
  assign w_misaligned   = |(req_addr[2:0] & w_size_m1);
  assign w_illegal      = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
  assign w_load_fmt     = (req_funct3[1:0] == 2'b11) ? 3'b101 : {1'b0, req_funct3[1:0]};

  always_comb begin
    w_err_code = 2'b00;
    if (w_illegal)           w_err_code = 2'b11;
    else if (w_misaligned)   w_err_code = 2'b01;
    else if (w_out_of_range) w_err_code = 2'b10;
  end

  always_comb begin
    w_load_ext = mem_rdata;
    case (r_funct3)
      3'b000: w_load_ext = {{56{mem_rdata[7]}},  mem_rdata[7:0]};
      3'b001: w_load_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010: w_load_ext = {{32{mem_rdata[31]}}, mem_rdata[31:0]};
      3'b100: w_load_ext = {56'd0, mem_rdata[7:0]};
      3'b101: w_load_ext = {48'd0, mem_rdata[15:0]};
      3'b110: w_load_ext = {32'd0, mem_rdata[31:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_funct3      <= 3'd0;
      resp_rdata    <= 64'd0;
      resp_err      <= 1'b0;
      resp_err_code <= 2'b00;
      mem_addr      <= 64'd0;
      mem_wdata     <= 64'd0;
      mem_write_en  <= 1'b0;
      mem_read_en   <= 1'b0;
      load_format   <= 3'b000;
      store_format  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_funct3   <= req_funct3;
            resp_rdata <= 64'd0;
            if (w_err_code != 2'b00) begin
              resp_err      <= 1'b1;
              resp_err_code <= w_err_code;
              r_state       <= S_RESP;
            end else begin
              resp_err      <= 1'b0;
              resp_err_code <= 2'b00;
              mem_addr      <= req_addr;
              mem_wdata     <= req_wdata;
              if (req_write) begin
                store_format <= req_funct3[1:0];
                mem_write_en <= 1'b1;
              end else begin
                load_format  <= w_load_fmt;
                mem_read_en  <= 1'b1;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          if (!r_write) resp_rdata <= w_load_ext;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
